// File: rtl/wb_shared_bus.sv
// Wishbone shared bus: N masters to M slaves, round-robin grant locked for the whole CYC, MSB address decode.
// Latency: one arbitration cycle, then combinational request/response paths; one dead cycle between owners.
// Backpressure: other masters wait until the owner drops CYC; `WB_SHARED_BUS_WATCHDOG_EN ends stalled strobes.
module wb_shared_bus #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEC_BITS    = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_MASTERS*AW-1:0]     m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0]   m_sel_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  output logic [DW-1:0]                 m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [NUM_MASTERS-1:0]        m_rty_o,
  output logic [AW-1:0]                 s_adr_o,
  output logic [DW-1:0]                 s_dat_o,
  output logic [DW/8-1:0]               s_sel_o,
  output logic                          s_we_o,
  output logic [NUM_SLAVES-1:0]         s_cyc_o,
  output logic [NUM_SLAVES-1:0]         s_stb_o,
  input  logic [NUM_SLAVES*DW-1:0]      s_dat_i,
  input  logic [NUM_SLAVES-1:0]         s_ack_i,
  input  logic [NUM_SLAVES-1:0]         s_err_i,
  input  logic [NUM_SLAVES-1:0]         s_rty_i,
  output logic [NUM_MASTERS-1:0]        grant_o
);
  localparam int MW = $clog2(NUM_MASTERS);

  typedef enum logic {IDLE, BUSY} state_t;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || NUM_SLAVES < 1 || NUM_SLAVES > 16 || (DW % 8) != 0 ||
      NUM_SLAVES > (2 ** DEC_BITS) || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
    $error("wb_shared_bus: parameter out of range");
  end

  state_t              state;
  logic [MW-1:0]       gidx;
  logic [MW-1:0]       last;
  logic                err_q;
  logic                err_done;
  logic                busy;
  logic                mapped;
  logic                g_cyc;
  logic                g_stb;
  logic                wd_hit;
  logic [AW-1:0]       g_adr;
  logic [DEC_BITS-1:0] dec;
  logic                nxt_vld;
  logic [MW-1:0]       nxt_idx;
  logic [MW-1:0]       cand;

  assign busy   = (state == BUSY);
  assign g_cyc  = m_cyc_i[gidx];
  assign g_stb  = m_stb_i[gidx];
  assign g_adr  = m_adr_i[gidx*AW +: AW];
  assign dec    = g_adr[AW-1 -: DEC_BITS];
  assign mapped = int'(dec) < NUM_SLAVES;

  // Round-robin search starting just above the previous owner.
  always_comb begin
    nxt_vld = 1'b0;
    nxt_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = MW'((int'(last) + i) % NUM_MASTERS);
      if (!nxt_vld && m_cyc_i[cand]) begin
        nxt_vld = 1'b1;
        nxt_idx = cand;
      end
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = '0;
    s_stb_o = '0;
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (busy) begin
      s_adr_o = g_adr;
      s_dat_o = m_dat_i[gidx*DW +: DW];
      s_sel_o = m_sel_i[gidx*(DW/8) +: DW/8];
      s_we_o  = m_we_i[gidx];
      for (int k = 0; k < NUM_SLAVES; k++) begin
        if (int'(dec) == k) begin
          s_cyc_o[k]    = g_cyc;
          s_stb_o[k]    = g_stb & ~wd_hit;
          m_ack_o[gidx] = s_ack_i[k];
          m_err_o[gidx] = s_err_i[k];
          m_rty_o[gidx] = s_rty_i[k];
          m_dat_o       = s_dat_i[k*DW +: DW];
        end
      end
      if (err_q || wd_hit) m_err_o[gidx] = 1'b1;
    end
  end

`ifdef WB_SHARED_BUS_WATCHDOG_EN
  logic [7:0] wd_cnt;
  logic       resp;

  assign resp   = err_q | (|((s_ack_i | s_err_i | s_rty_i) & s_cyc_o));
  assign wd_hit = busy && (wd_cnt == 8'(TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wd_cnt <= '0;
    end else if (!busy || !g_stb || resp || wd_hit) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      gidx     <= '0;
      last     <= MW'(NUM_MASTERS - 1);
      grant_o  <= '0;
      err_q    <= 1'b0;
      err_done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (nxt_vld) begin
          state   <= BUSY;
          gidx    <= nxt_idx;
          grant_o <= NUM_MASTERS'(1) << nxt_idx;
        end
        BUSY: if (!g_cyc) begin
          state   <= IDLE;
          last    <= gidx;
          grant_o <= '0;
        end
        default: state <= IDLE;
      endcase
      // One unmapped-address error per strobe; a held strobe stays quiet until it drops.
      err_q    <= busy && !mapped && g_cyc && g_stb && !err_q && !err_done;
      err_done <= busy && g_stb && (err_q || err_done);
    end
  end
endmodule

// File: tb/tb_wb_shared_bus.sv
// Directed bench for wb_shared_bus: 2 masters, 2 slaves, TIMEOUT=8.
module tb_wb_shared_bus;
  localparam int NM = 2;
  localparam int NS = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                 clk_i = 1'b0;
  logic                 rst_n_i = 1'b0;
  logic [NM*AW-1:0]     m_adr_i;
  logic [NM*DW-1:0]     m_dat_i;
  logic [NM*DW/8-1:0]   m_sel_i;
  logic [NM-1:0]        m_we_i, m_cyc_i, m_stb_i;
  logic [DW-1:0]        m_dat_o;
  logic [NM-1:0]        m_ack_o, m_err_o, m_rty_o, grant_o;
  logic [AW-1:0]        s_adr_o;
  logic [DW-1:0]        s_dat_o;
  logic [DW/8-1:0]      s_sel_o;
  logic                 s_we_o;
  logic [NS-1:0]        s_cyc_o, s_stb_o;
  logic [NS*DW-1:0]     s_dat_i;
  logic [NS-1:0]        s_ack_i, s_err_i, s_rty_i;

  int n_cmp = 0;
  int n_mis = 0;
  int acks;
  int err_total;
  int first_err;
  logic stb_at_err;

  always #5 clk_i = ~clk_i;

  wb_shared_bus #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .AW(AW), .DW(DW), .DEC_BITS(4), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .grant_o(grant_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;
    s_dat_i = '0; s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
  endtask

  task automatic do_reset;
    rst_n_i = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n_i = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL tb_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state, with slave responses that must not leak through.
    clear_inputs();
    rst_n_i = 1'b0;
    s_ack_i = 2'b11;
    s_dat_i = {32'h5555_6666, 32'h7777_8888};
    #2;
    check_eq("rst_grant", grant_o, 0);
    check_eq("rst_s_cyc", {s_cyc_o, s_stb_o}, 0);
    check_eq("rst_m_resp", {m_ack_o, m_err_o, m_rty_o}, 0);
    check_eq("rst_m_dat", m_dat_o, 0);
    check_eq("rst_s_bus", {s_adr_o, s_we_o}, 0);
    do_reset();

    // Single read by master 0, slave 0 acks two cycles into the grant.
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_adr_i[0 +: AW] = 32'h0000_0010;
    #1;
    check_eq("t1_req_no_fwd", s_cyc_o, 2'b00);
    step();
    check_eq("t1_grant", grant_o, 2'b01);
    check_eq("t1_s_cyc", s_cyc_o, 2'b01);
    check_eq("t1_s_stb", s_stb_o, 2'b01);
    check_eq("t1_s_adr", s_adr_o, 32'h0000_0010);
    step();
    check_eq("t1_wait_ack", m_ack_o, 2'b00);
    step();
    s_ack_i = 2'b01; s_dat_i = {32'h1111_2222, 32'hCAFE_0001};
    #1;
    check_eq("t1_ack", m_ack_o, 2'b01);
    check_eq("t1_rdata", m_dat_o, 32'hCAFE_0001);
    step();
    s_ack_i = '0; m_cyc_i = '0; m_stb_i = '0;
    #1;
    check_eq("t1_cyc_drop", s_cyc_o, 2'b00);
    check_eq("t1_grant_held", grant_o, 2'b01);
    step();
    check_eq("t1_grant_clr", grant_o, 2'b00);

    // Both masters request together: 0,1,0,1 with a dead cycle between owners.
    do_reset();
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    step();
    for (int r = 0; r < 4; r++) begin
      check_eq($sformatf("t2_grant_%0d", r), grant_o, 2'b01 << (r % 2));
      m_cyc_i[r % 2] = 1'b0; m_stb_i[r % 2] = 1'b0;
      step();
      check_eq($sformatf("t2_gap_%0d", r), grant_o, 2'b00);
      m_cyc_i[r % 2] = 1'b1; m_stb_i[r % 2] = 1'b1;
      step();
    end
    clear_inputs();
    step();

    // Master 1 holds a locked cycle over three strobes while master 0 waits.
    do_reset();
    m_cyc_i[1] = 1'b1; m_adr_i[AW +: AW] = 32'h1000_0004; m_dat_i[DW +: DW] = 32'hDEAD_BEEF;
    m_sel_i[4 +: 4] = 4'b1010; m_we_i[1] = 1'b1;
    step();
    check_eq("t3_grant_m1", grant_o, 2'b10);
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
    acks = 0;
    for (int s = 0; s < 3; s++) begin
      m_stb_i[1] = 1'b1; s_ack_i = 2'b10;
      #1;
      check_eq($sformatf("t3_s_stb_%0d", s), s_stb_o, 2'b10);
      check_eq($sformatf("t3_ack_%0d", s), m_ack_o, 2'b10);
      if (s == 0) begin
        check_eq("t3_wdata", s_dat_o, 32'hDEAD_BEEF);
        check_eq("t3_sel_we", {s_sel_o, s_we_o}, 5'b10101);
        check_eq("t3_adr", s_adr_o, 32'h1000_0004);
      end
      acks += int'(m_ack_o[1]);
      step();
      m_stb_i[1] = 1'b0; s_ack_i = '0;
      #1;
      check_eq($sformatf("t3_locked_%0d", s), grant_o, 2'b10);
      step();
    end
    check_eq("t3_ack_count", acks, 3);
    m_cyc_i[1] = 1'b0; m_we_i[1] = 1'b0;
    step();
    check_eq("t3_release", grant_o, 2'b00);
    step();
    check_eq("t3_m0_granted", grant_o, 2'b01);
    clear_inputs();
    step();

    // Unmapped address: one err per strobe, slave acks ignored.
    do_reset();
    s_ack_i = 2'b11;
    #1;
    check_eq("t4_idle_resp", {m_ack_o, m_err_o}, 0);
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_adr_i[0 +: AW] = 32'h3000_0000;
    step();
    check_eq("t4_no_strobe", {s_cyc_o, s_stb_o}, 0);
    check_eq("t4_no_err_yet", m_err_o, 2'b00);
    check_eq("t4_no_ack", m_ack_o, 2'b00);
    step();
    check_eq("t4_err_pulse", m_err_o, 2'b01);
    err_total = 0;
    repeat (4) begin
      step();
      err_total += int'(m_err_o[0]);
    end
    check_eq("t4_no_repeat", err_total, 0);
    m_stb_i[0] = 1'b0;
    step();
    m_stb_i[0] = 1'b1;
    step();
    check_eq("t4_rearm", m_err_o, 2'b01);
    clear_inputs();
    step();

    // Slave 0 never responds.
    do_reset();
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
    step();
    first_err = 0;
    stb_at_err = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      if (m_err_o[0] && first_err == 0) begin
        first_err = c;
        stb_at_err = s_stb_o[0];
      end
      step();
    end
`ifdef WB_SHARED_BUS_WATCHDOG_EN
    check_eq("t5_wd_first_err", first_err, 9);
    check_eq("t5_wd_stb_low", stb_at_err, 1'b0);
`else
    check_eq("t5_no_wd_err", first_err, 0);
    check_eq("t5_still_strobed", s_stb_o, 2'b01);
`endif
    clear_inputs();
    step();

    // Reset while slave 1 is strobed; afterwards master 0 wins again.
    do_reset();
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
    step();
    s_ack_i = 2'b01;
    step();
    clear_inputs();
    step();
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_adr_i[0 +: AW] = 32'h1000_0000;
    step();
    check_eq("t6_pre_stb", s_stb_o, 2'b10);
    s_ack_i = 2'b10; m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1;
    #2;
    rst_n_i = 1'b0;
    #1;
    check_eq("t6_rst_s_cyc", {s_cyc_o, s_stb_o}, 0);
    check_eq("t6_rst_no_ack", {m_ack_o, m_err_o}, 0);
    check_eq("t6_rst_grant", grant_o, 2'b00);
    step();
    step();
    rst_n_i = 1'b1;
    #1;
    check_eq("t6_idle_after", grant_o, 2'b00);
    step();
    check_eq("t6_first_grant", grant_o, 2'b01);
    clear_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
